// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding and default bus widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

  localparam int APB_ADDR_W_DEF = 8;
  localparam int APB_DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-winner pointer.
// Latency: grant is combinational from req; pointer moves on the edge where update is high.
// Backpressure: none; the caller pulses update only when it actually accepts the grant.
module apb_rr_arbiter2
  import apb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  // 1 when requester 1 won last, so requester 0 is favoured on a tie.
  logic last_was1;

  // Grant the lone requester, or on a tie the one that did not win last.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_was1 ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the accepted winner; reset makes requester 0 the first favourite.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_was1 <= 1'b1;
    end else if (update && (gnt != 2'b00)) begin
      last_was1 <= gnt[1];
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin grant, IDLE->SETUP->ACCESS transfer, done/err pulse per transfer.
// Latency: request sampled in IDLE at edge N, SETUP N+1, ACCESS N+2, done N+3 with zero wait states.
// Backpressure: apb_ready low stretches ACCESS; with APB_TIMEOUT_EN defined the wait is capped at TIMEOUT_CYCLES.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W_DEF,
  parameter int DATA_W         = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        req_write,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] rdata_out,
  output logic              err,
  output logic              apb_sel,
  output logic              apb_enable,
  output logic              apb_write,
  output logic [ADDR_W-1:0] apb_addr,
  output logic [DATA_W-1:0] apb_wdata,
  input  logic              apb_ready,
  input  logic [DATA_W-1:0] apb_rdata
);

  apb_state_t        state, state_nxt;
  logic [1:0]        arb_gnt;
  logic              start;     // IDLE accepts a request this cycle
  logic              complete;  // ACCESS ends this cycle (ready or abort)
  logic              timeout;   // ACCESS ends by abort rather than ready
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  apb_rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .update (start),
    .gnt    (arb_gnt)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and APB phase strobes; apb_ready only matters in ACCESS.
  always_comb begin
    state_nxt  = state;
    start      = 1'b0;
    complete   = 1'b0;
    apb_sel    = 1'b0;
    apb_enable = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          start     = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        apb_sel   = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        apb_sel    = 1'b1;
        apb_enable = 1'b1;
        if (apb_ready || timeout) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner's command at grant time, then pulse done and capture read data at the end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= 2'b00;
      done      <= 2'b00;
      rdata_out <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      done <= 2'b00;
      if (start) begin
        gnt <= arb_gnt;
        if (arb_gnt[1]) begin
          wr_q    <= req_write[1];
          addr_q  <= req_addr1;
          wdata_q <= req_wdata1;
        end else begin
          wr_q    <= req_write[0];
          addr_q  <= req_addr0;
          wdata_q <= req_wdata0;
        end
      end
      if (complete) begin
        gnt  <= 2'b00;
        done <= gnt;
        if (!wr_q && !timeout) rdata_out <= apb_rdata;
      end
    end
  end

  assign apb_write = wr_q;
  assign apb_addr  = addr_q;
  assign apb_wdata = wdata_q;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] acc_cnt;

  // Count stalled ACCESS cycles; SETUP clears it so every transfer starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               acc_cnt <= '0;
    else if (state == SETUP)                 acc_cnt <= '0;
    else if (state == ACCESS && !apb_ready)  acc_cnt <= acc_cnt + 1'b1;
  end

  // Abort on the last allowed stalled cycle; a ready in that cycle still wins.
  assign timeout = (state == ACCESS) && !apb_ready &&
                   (acc_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // err travels with the done pulse of an aborted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= complete && timeout;
  end
`else
  // No abort path in this build; the comparison is never true for a count parameter.
  assign timeout = (TIMEOUT_CYCLES < 0);
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] req_write = 2'b00;
  logic [7:0] req_addr0 = 8'h00, req_addr1 = 8'h00;
  logic [7:0] req_wdata0 = 8'h00, req_wdata1 = 8'h00;
  logic [1:0] gnt, done;
  logic [7:0] rdata_out;
  logic       err;
  logic       apb_sel, apb_enable, apb_write;
  logic [7:0] apb_addr, apb_wdata;
  logic       apb_ready = 1'b1;
  logic [7:0] apb_rdata = 8'h00;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  apb_master_arbiter #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .gnt(gnt), .done(done), .rdata_out(rdata_out), .err(err),
    .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata),
    .apb_ready(apb_ready), .apb_rdata(apb_rdata)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] wr;
    logic [7:0] a0, a1, w0, w1;
    int         waits;
    logic [7:0] srd;
    logic [1:0] e_gnt;
    logic [7:0] e_addr, e_wdata;
    logic       e_write;
    logic [7:0] e_rdata;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer from IDLE, checked phase by phase.
  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, "_idle_sel"}, apb_sel, 0);
    req = v.req; req_write = v.wr;
    req_addr0 = v.a0; req_addr1 = v.a1; req_wdata0 = v.w0; req_wdata1 = v.w1;
    apb_ready = 1'b1;            // must be ignored outside ACCESS
    apb_rdata = 8'hEE;
    tick();
    chk({p, "_setup_gnt"}, gnt, v.e_gnt);
    chk({p, "_setup_phase"}, {apb_sel, apb_enable}, 2'b10);
    chk({p, "_setup_addr"}, apb_addr, v.e_addr);
    chk({p, "_setup_write"}, apb_write, v.e_write);
    chk({p, "_setup_wdata"}, apb_wdata, v.e_wdata);
    // Requester side changes after latching must not disturb the transfer.
    req = 2'b00; req_write = ~v.wr;
    req_addr0 = ~v.a0; req_addr1 = ~v.a1; req_wdata0 = ~v.w0; req_wdata1 = ~v.w1;
    apb_ready = (v.waits == 0);
    apb_rdata = (v.waits == 0) ? v.srd : 8'hEE;
    tick();
    chk({p, "_access_phase"}, {apb_sel, apb_enable}, 2'b11);
    chk({p, "_access_addr"}, apb_addr, v.e_addr);
    for (int w = 0; w < v.waits; w++) begin
      tick();
      chk({p, "_wait_hold"}, {apb_sel, apb_enable, done}, 4'b1100);
      chk({p, "_wait_addr"}, apb_addr, v.e_addr);
      if (w == v.waits - 1) begin
        apb_ready = 1'b1;
        apb_rdata = v.srd;
      end
    end
    tick();
    chk({p, "_done"}, done, v.e_gnt);
    chk({p, "_gnt_clr"}, gnt, 0);
    chk({p, "_idle_after"}, apb_sel, 0);
    chk({p, "_rdata"}, rdata_out, v.e_rdata);
    chk({p, "_err"}, err, 0);
    tick();
    chk({p, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int bad;
    logic [1:0] eg, ed;
    int ph, own;

    //           req    wr     a0     a1     w0     w1    wt srd    gnt    addr   wdata  w  rdata
    tbl[0] = '{2'b01, 2'b01, 8'h06, 8'h00, 8'h05, 8'h00, 0, 8'h77, 2'b01, 8'h06, 8'h05, 1, 8'h00};
    tbl[1] = '{2'b10, 2'b00, 8'h00, 8'h06, 8'h00, 8'h00, 5, 8'h05, 2'b10, 8'h06, 8'h00, 0, 8'h05};
    tbl[2] = '{2'b11, 2'b10, 8'h12, 8'h56, 8'h34, 8'h78, 1, 8'hA5, 2'b01, 8'h12, 8'h34, 0, 8'hA5};
    tbl[3] = '{2'b11, 2'b10, 8'h12, 8'h56, 8'h34, 8'h78, 0, 8'h3C, 2'b10, 8'h56, 8'h78, 1, 8'hA5};
    tbl[4] = '{2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00, 2, 8'hC3, 2'b01, 8'hFF, 8'h00, 0, 8'hC3};
    tbl[5] = '{2'b01, 2'b01, 8'h80, 8'h00, 8'h01, 8'h00, 0, 8'h99, 2'b01, 8'h80, 8'h01, 1, 8'hC3};

    // Reset values.
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_phase", {apb_sel, apb_enable}, 0);
    chk("rst_write", apb_write, 0);
    chk("rst_addr", apb_addr, 0);
    chk("rst_wdata", apb_wdata, 0);
    chk("rst_rdata", rdata_out, 0);
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // Continuous dual request after reset: 01,10,01,10 with an IDLE cycle between.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 2'b11; req_write = 2'b00; req_addr0 = 8'h01; req_addr1 = 8'h02;
    apb_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      ph  = k % 3;
      own = (k / 3) % 2;
      eg  = (ph < 2) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
      ed  = (ph == 2) ? ((own == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk($sformatf("rr_gnt_c%0d", k), gnt, eg);
      chk($sformatf("rr_sel_c%0d", k), apb_sel, (ph < 2));
      chk($sformatf("rr_done_c%0d", k), done, ed);
      if (ph == 0) chk($sformatf("rr_addr_c%0d", k), apb_addr, (own == 1) ? 8'h02 : 8'h01);
    end
    req = 2'b00;
    tick();
    chk("rr_no_req_idle", apb_sel, 0);

    // Reset while ACCESS is stalled: strobes drop at once, no done afterwards.
    req = 2'b01; req_write = 2'b00; req_addr0 = 8'h09; apb_ready = 1'b0;
    tick();
    req = 2'b00;
    tick();
    tick();
    chk("mid_in_access", {apb_sel, apb_enable}, 2'b11);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_phase", {apb_sel, apb_enable}, 0);
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_done", done, 0);
    tick();
    apb_ready = 1'b1;
    apb_rdata = 8'h5A;
    tick();
    reset = 1'b0;
    tick();
    chk("mid_post_done", done, 0);
    chk("mid_post_sel", apb_sel, 0);
    req = 2'b10; req_write = 2'b00; req_addr1 = 8'h44;
    tick();
    chk("mid_regrant_gnt", gnt, 2'b10);
    chk("mid_regrant_addr", apb_addr, 8'h44);
    req = 2'b00;
    tick();
    tick();
    chk("mid_regrant_done", done, 2'b10);
    chk("mid_regrant_rdata", rdata_out, 8'h5A);
    tick();

    // Slave never ready.
    req = 2'b01; req_write = 2'b01; req_addr0 = 8'h21; req_wdata0 = 8'h43;
    apb_ready = 1'b0; apb_rdata = 8'h66;
    tick();
    req = 2'b00;
    tick();
    chk("stall_access", {apb_sel, apb_enable}, 2'b11);
`ifdef APB_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!(apb_sel && apb_enable) || done != 2'b00 || err) bad++;
    end
    chk("to_hold_16", bad, 0);
    tick();
    chk("to_done", done, 2'b01);
    chk("to_err", err, 1);
    chk("to_idle", apb_sel, 0);
    chk("to_rdata_kept", rdata_out, 8'h5A);
    tick();
    chk("to_err_pulse", {err, done}, 0);
`else
    bad = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (!(apb_sel && apb_enable) || done != 2'b00 || err) bad++;
    end
    chk("stall_hold_120", bad, 0);
    apb_ready = 1'b1;
    tick();
    chk("stall_done", done, 2'b01);
    chk("stall_err", err, 0);
    chk("stall_rdata_kept", rdata_out, 8'h5A);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 SHALL have parameter DATA_W, default 8, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS cycles before abort (used only with APB_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports req  input  2, req_write  input  2  per-requester transfer request and direction (1 = write).
REQ-007 SHALL have ports req_addr0/req_addr1  input  ADDR_W and req_wdata0/req_wdata1  input  DATA_W  per-requester address and write data.
REQ-008 SHALL have ports gnt  output  2 (one-hot owner of current transfer), done  output  2 (one-cycle completion pulse), rdata_out  output  DATA_W (read result), err  output  1 (timeout flag, pulses with done).
REQ-009 SHALL have APB master ports apb_sel, apb_enable, apb_write  output  1; apb_addr  output  ADDR_W; apb_wdata  output  DATA_W; apb_ready  input  1; apb_rdata  input  DATA_W.

Function
REQ-010 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE; no other states.
REQ-011 In IDLE with any req bit set, SHALL grant one requester, latch its write/addr/wdata, assert gnt, and enter SETUP on the next edge.
REQ-012 Arbitration SHALL be round-robin: on simultaneous req, grant the requester not granted last; after reset requester 0 has priority.
REQ-013 In SETUP: apb_sel=1, apb_enable=0, addr/write/wdata driven from latched values; SHALL enter ACCESS unconditionally after one cycle.
REQ-014 In ACCESS: apb_sel=1, apb_enable=1, addr/write/wdata held stable; SHALL remain in ACCESS while apb_ready=0 (wait states, unbounded without APB_TIMEOUT_EN).
REQ-015 On clk edge with ACCESS and apb_ready=1: SHALL pulse done[owner] for exactly one cycle, capture apb_rdata into rdata_out on reads (rdata_out unchanged on writes), clear gnt, return to IDLE.
REQ-016 Zero-wait transfer latency: request sampled in IDLE at edge N, SETUP in cycle N+1, ACCESS in N+2, done high in N+3.
REQ-017 SHALL insert at least one IDLE cycle between consecutive transfers (apb_sel low one cycle).
REQ-018 Requester inputs SHALL be ignored after latching; deassertion of req mid-transfer SHALL NOT abort it.
REQ-019 apb_ready SHALL be ignored in IDLE and SETUP.
REQ-020 A requester holding req after its done SHALL be re-granted only if the other requester is not requesting.

Reset
REQ-021 On reset assertion, asynchronously: state=IDLE, gnt=0, done=0, err=0, apb_sel=0, apb_enable=0, apb_write=0, apb_addr=0, apb_wdata=0, rdata_out=0, round-robin pointer favours requester 0.
REQ-022 Reset mid-transfer SHALL abandon the transfer with no done pulse; first post-reset grant SHALL follow REQ-011.

Configuration
REQ-023 Macro APB_TIMEOUT_EN defined: cycle counter resets on ACCESS entry; if apb_ready still 0 after TIMEOUT_CYCLES ACCESS cycles, SHALL return to IDLE, pulse done[owner] and err together, leave rdata_out unchanged.
REQ-024 Macro APB_TIMEOUT_EN undefined: no counter logic; err tied to 0; ACCESS waits indefinitely.

Structure
REQ-025 Shared package apb_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS) and default ADDR_W/DATA_W constants.
REQ-026 Arbitration SHALL live in sub-module apb_rr_arbiter2 (req[1:0], update pulse -> one-hot grant, registered last-grant pointer).

Verification
REQ-027 req=01, write, addr=6, wdata=5, apb_ready=1 constant -> SETUP cycle then ACCESS cycle, done=01 three cycles after request, apb_addr=6, apb_wdata=5.
REQ-028 req=10, read, addr=6, slave returns 5 after 5 wait cycles -> ACCESS held 6 cycles with stable addr, done=10, rdata_out=5.
REQ-029 req=11 held continuously, zero wait -> grants alternate 01,10,01,10 with one IDLE cycle between transfers.
REQ-030 Reset asserted during ACCESS with 3 wait cycles pending -> apb_sel/apb_enable drop immediately, no done pulse, next req=10 granted first-come.
REQ-031 APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, apb_ready held 0 -> after 16 ACCESS cycles done[owner]=1 and err=1 same cycle, FSM IDLE; without macro, ACCESS persists 100+ cycles, err=0.
